// File: rtl/mpsoc_msi_pkg.sv
// Shared AHB3-Lite constants and types for the multi-master interconnect.
package mpsoc_msi_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HWORD = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StOwned,
        StLock
    } arb_state_t;

endpackage

// File: rtl/mpsoc_msi_ahb3_slave_arbiter_if.sv
// Request/grant bundle between the interconnect and one slave-port arbiter.
interface mpsoc_msi_ahb3_slave_arbiter_if #(
    parameter int unsigned MASTERS   = 5,
    parameter int unsigned PRIO_BITS = 3
);

    logic [MASTERS-1:0][PRIO_BITS-1:0] mst_priority;
    logic [MASTERS-1:0]                mst_req;
    logic [MASTERS-1:0][1:0]           mst_HTRANS;
    logic [MASTERS-1:0]                mst_HMASTLOCK;
    logic                              slv_HREADY;
    logic [MASTERS-1:0]                grant;
    logic [$clog2(MASTERS)-1:0]        grant_id;
    logic [MASTERS-1:0]                dphase_grant;
    logic                              dphase_valid;
    logic                              locked;

    modport master (
        output mst_priority, mst_req, mst_HTRANS, mst_HMASTLOCK, slv_HREADY,
        input  grant, grant_id, dphase_grant, dphase_valid, locked
    );

    modport slave (
        input  mst_priority, mst_req, mst_HTRANS, mst_HMASTLOCK, slv_HREADY,
        output grant, grant_id, dphase_grant, dphase_valid, locked
    );

endinterface

// File: rtl/mpsoc_msi_rr_prio_select.sv
// Combinational priority select with round-robin tie break starting after last_owner.
module mpsoc_msi_rr_prio_select
    import mpsoc_msi_pkg::*;
#(
    parameter int unsigned MASTERS   = 5,
    parameter int unsigned PRIO_BITS = 3
) (
    input  logic [MASTERS-1:0]                req,
    input  logic [MASTERS-1:0][PRIO_BITS-1:0] prio,
    input  logic [$clog2(MASTERS)-1:0]        last_owner,
    output logic [MASTERS-1:0]                winner,
    output logic [$clog2(MASTERS)-1:0]        winner_id
);

    localparam int unsigned IdW = $clog2(MASTERS);
    localparam logic [IdW:0] MastersW = (IdW + 1)'(MASTERS);

    logic [PRIO_BITS-1:0] max_prio;
    logic [IdW:0]         sum;
    logic [IdW-1:0]       idx;
    logic                 found;

    always_comb begin
        max_prio = '0;
        for (int i = 0; i < MASTERS; i++) begin
            if (req[i] && (prio[i] > max_prio)) begin
                max_prio = prio[i];
            end
        end

        winner    = '0;
        winner_id = '0;
        found     = 1'b0;
        sum       = '0;
        idx       = '0;
        // Walk indices last_owner+1 .. last_owner+MASTERS, wrapping modulo MASTERS.
        for (int off = 1; off <= MASTERS; off++) begin
            sum = {1'b0, last_owner} + (IdW + 1)'(off);
            if (sum >= MastersW) begin
                sum = sum - MastersW;
            end
            idx = sum[IdW-1:0];
            if (!found && req[idx] && (prio[idx] == max_prio)) begin
                found       = 1'b1;
                winner[idx] = 1'b1;
                winner_id   = idx;
            end
        end
    end

endmodule

// File: rtl/mpsoc_msi_ahb3_slave_arbiter.sv
// Per-slave-port AHB3-Lite arbiter: address-phase owner FSM, burst/lock holds and
// data-phase owner tracking.
module mpsoc_msi_ahb3_slave_arbiter
    import mpsoc_msi_pkg::*;
#(
    parameter int unsigned MASTERS   = 5,
    parameter int unsigned PRIO_BITS = 3
) (
    input logic HCLK,
    input logic HRESETn,
    mpsoc_msi_ahb3_slave_arbiter_if.slave bus
);

    localparam int unsigned IdW = $clog2(MASTERS);

    arb_state_t         state_q, state_d;
    logic [MASTERS-1:0] grant_q, grant_d;
    logic [IdW-1:0]     grant_id_q, grant_id_d;
    logic [IdW-1:0]     last_q, last_d;
    logic [MASTERS-1:0] dgrant_q, dgrant_d;
    logic               dvalid_q, dvalid_d;
    logic               locked_q, locked_d;

    logic [MASTERS-1:0] win;
    logic [IdW-1:0]     win_id;

    logic               owner_act;
    logic               owner_req;
    logic               owner_lock;
    logic [1:0]         owner_htrans;
    logic               burst_hold;
    logic               do_arb;

    mpsoc_msi_rr_prio_select #(
        .MASTERS   (MASTERS),
        .PRIO_BITS (PRIO_BITS)
    ) u_select (
        .req        (bus.mst_req),
        .prio       (bus.mst_priority),
        .last_owner (last_q),
        .winner     (win),
        .winner_id  (win_id)
    );

    // Owner-side views are only meaningful while grant_q is non-zero.
    assign owner_act    = |grant_q;
    assign owner_req    = |(grant_q & bus.mst_req);
    assign owner_htrans = bus.mst_HTRANS[grant_id_q];
    assign owner_lock   = owner_act & bus.mst_HMASTLOCK[grant_id_q];
    assign burst_hold   = owner_req &
                          ((owner_htrans == HTRANS_SEQ) || (owner_htrans == HTRANS_BUSY));

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        last_d     = last_q;
        dgrant_d   = dgrant_q;
        dvalid_d   = dvalid_q;
        locked_d   = locked_q;
        do_arb     = 1'b0;

        if (bus.slv_HREADY) begin
            dgrant_d = grant_q;
            dvalid_d = owner_act &&
                       ((owner_htrans == HTRANS_NONSEQ) || (owner_htrans == HTRANS_SEQ));

            unique case (state_q)
                StIdle: begin
                    do_arb = 1'b1;
                end
                StOwned, StLock: begin
                    if (owner_lock) begin
                        state_d  = StLock;
                        locked_d = 1'b1;
                    end else if (burst_hold) begin
                        state_d  = StOwned;
                        locked_d = 1'b0;
                    end else begin
                        do_arb = 1'b1;
                    end
                end
                default: begin
                    do_arb = 1'b1;
                end
            endcase

            if (do_arb) begin
                locked_d = 1'b0;
                if (|win) begin
                    state_d    = StOwned;
                    grant_d    = win;
                    grant_id_d = win_id;
                    last_d     = win_id;
                end else begin
                    // No parking: an empty arbitration leaves the port ownerless.
                    state_d    = StIdle;
                    grant_d    = '0;
                    grant_id_d = '0;
                end
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            grant_id_q <= '0;
            last_q     <= IdW'(MASTERS - 1);
            dgrant_q   <= '0;
            dvalid_q   <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            last_q     <= last_d;
            dgrant_q   <= dgrant_d;
            dvalid_q   <= dvalid_d;
            locked_q   <= locked_d;
        end
    end

    assign bus.grant        = grant_q;
    assign bus.grant_id     = grant_id_q;
    assign bus.dphase_grant = dgrant_q;
    assign bus.dphase_valid = dvalid_q;
    assign bus.locked       = locked_q;

endmodule

// File: doc/mpsoc_msi_ahb3_slave_arbiter.md
# mpsoc_msi_ahb3_slave_arbiter

Per-slave-port arbiter for the multi-master AHB3-Lite interconnect. It decides which of MASTERS requesters owns one slave port's address phase, tracks which master owns the data phase, and holds ownership across bursts and locked sequences. Priority is per-master, and ties are broken round-robin. One instance sits in front of each slave port; its grant vectors steer the interconnect's address, write-data and read-data muxes.

## Interface
Parameters:
- MASTERS, 5: number of requesting masters (≥2).
- PRIO_BITS, 3: width of each master priority.

Ports:
- HCLK, in, 1: the single clock.
- HRESETn, in, 1: asynchronous, active-low reset.
- mst_priority, in, [MASTERS][PRIO_BITS]: static priority per master; a larger value wins.
- mst_req, in, MASTERS: master has a pending transfer decoded to this slave. Held high by the interconnect until accepted.
- mst_HTRANS, in, [MASTERS][2]: each master's current HTRANS (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
- mst_HMASTLOCK, in, MASTERS: each master's HMASTLOCK.
- slv_HREADY, in, 1: slave HREADYOUT; 1 means the current transfer completes this cycle.
- grant, out, MASTERS: one-hot address-phase owner, or all zero when there is none.
- grant_id, out, $clog2(MASTERS): encoded owner; 0 when there is none.
- dphase_grant, out, MASTERS: one-hot data-phase owner, used for the HRDATA/HRESP/HWDATA mux.
- dphase_valid, out, 1: a real (NONSEQ/SEQ) transfer is in its data phase.
- locked, out, 1: ownership is held by HMASTLOCK.

## Operation
- FSM states: IDLE (no owner), OWNED, LOCK. All outputs are registered.
- Arbitration point: a rising HCLK edge with slv_HREADY=1, where the state is not a "hold".
- Holds that keep the current owner:
  - The owner has mst_req=1 with HTRANS SEQ or BUSY (mid-burst).
  - The owner has HMASTLOCK=1. This moves the FSM to LOCK and asserts locked.
- Winner selection: among masters with mst_req=1, pick the highest mst_priority.
  - Ties are broken round-robin, starting at index (last_owner+1) mod MASTERS and wrapping.
  - The current owner presenting a new NONSEQ therefore yields to an equal-priority requester.
  - A strictly higher-priority requester pre-empts at the next burst boundary only, never mid-burst.
- No requester at an arbitration point: grant=0 and the FSM goes to IDLE. There is no bus parking.
- last_owner updates only when a non-zero grant is issued. Its reset value is MASTERS-1, so master 0 is first in round-robin order.
- Leaving LOCK: at an arbitration point where the owner's HMASTLOCK=0, normal arbitration runs. The owner stays in the tie rotation.
- Data phase: on an edge with slv_HREADY=1:
  - dphase_grant <= grant.
  - dphase_valid <= (grant≠0 and the owner's HTRANS ∈ {NONSEQ, SEQ}).
  - When slv_HREADY=0, both hold their values.
- If the owner drops mst_req while the FSM is in OWNED, this is a normal arbitration point, provided slv_HREADY=1.
- Width rules:
  - grant_id is the binary encoding of grant.
  - Priority comparison is unsigned, over PRIO_BITS bits.
  - Round-robin index arithmetic is modulo MASTERS. Non-power-of-two MASTERS must wrap correctly.

## Timing
- Reset (asynchronous assert, synchronous release): grant=0, grant_id=0, dphase_grant=0, dphase_valid=0, locked=0, state=IDLE, last_owner=MASTERS-1.
- Grant latency: mst_req sampled high at edge N, with the arbiter idle and slv_HREADY=1, gives grant valid after edge N. This is a 1-cycle request-to-grant latency.
- The data-phase owner lags the address-phase owner by exactly one accepted (HREADY=1) cycle.
- slv_HREADY=0 freezes grant, dphase_grant, state and last_owner. Wait states never cause a grant change.
- Reset asserted mid-burst or mid-lock: all state clears immediately. No completion of the outstanding transfer is attempted.
- Simultaneous requests at equal priority: exactly one grant. The selection is fully deterministic from last_owner.

## Structure
- Add to a shared package, mpsoc_msi_pkg, next to the existing AHB constants:
  - HTRANS encodings HTRANS_IDLE/BUSY/NONSEQ/SEQ.
  - The FSM state enum arb_state_t.
- Sub-module mpsoc_msi_rr_prio_select:
  - Purely combinational.
  - Inputs: request vector, priority array, last_owner.
  - Outputs: one-hot winner and its encoded id.
  - Reused by other arbiters in the interconnect.
- The top module holds the FSM, the last_owner register and the data-phase registers.

## Test plan
- Reset release with no requests: all outputs 0 and the FSM in IDLE. Then mst_req=5'b00100 with HTRANS=NONSEQ and slv_HREADY=1 gives grant=5'b00100 and grant_id=2 one cycle later, and dphase_grant=5'b00100 with dphase_valid=1 the cycle after.
- Equal priorities of 0, all five masters requesting NONSEQ continuously with single transfers: grants rotate 0,1,2,3,4,0 on consecutive accepted cycles.
- Master 1 in a 4-beat burst (NONSEQ, then SEQ×3) while master 3 (priority 7 vs 1) requests: master 1 keeps the grant through all SEQ beats. Master 3 is granted at the first edge after the last beat.
- slv_HREADY held 0 for 3 cycles mid-burst: grant, dphase_grant and dphase_valid are unchanged throughout. Progress resumes on the first HREADY=1.
- Master 4 with HMASTLOCK=1 across two NONSEQ transfers, master 0 requesting at higher priority: locked=1 and grant stays 5'b10000 until master 4 deasserts HMASTLOCK. Master 0 is granted at the next arbitration point.
- HRESETn pulsed low during LOCK with slv_HREADY=0: outputs go to 0 asynchronously. After release, the first equal-priority grant goes to master 0.
